// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient update path.
package fir_pkg;

    localparam int FIR_COEF_WIDTH = 18;
    localparam int FIR_DSP_NR     = 32;
    localparam int FIR_COEF_MAG   = (1 << (FIR_COEF_WIDTH - 1)) - 1;

    // Bit positions inside the FIR switch/control register
    localparam int SWITCH_CON_EST    = 0;
    localparam int SWITCH_FIR_EN     = 1;
    localparam int SWITCH_FIR_UPDATE = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } fir_state_e;

    typedef logic signed [FIR_COEF_WIDTH-1:0] fir_coef_t;

endpackage

// File: rtl/fir_coef_shadow.sv
// Shadow coefficient bank: one synchronous write port, one combinational
// indexed read port. Software fills it while the controller is idle.
module fir_coef_shadow #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] bank_q [DEPTH];

    // Bank storage: cleared on reset, written one entry per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            bank_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/fir_coef_update_ctrl.sv
// FIR coefficient update sequencer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | shadow writes accepted, active bank stable, hold released
//   ST_LOAD  | copy shadow -> active, one tap per cycle, FIR held
//   ST_FLUSH | wait for tap pipeline + output register to drain
module fir_coef_update_ctrl #(
    parameter int FIR_COEF_WIDTH = fir_pkg::FIR_COEF_WIDTH,
    parameter int FIR_DSP_NR     = fir_pkg::FIR_DSP_NR,
    parameter int IDX_W          = $clog2(FIR_DSP_NR)
) (
    input  logic                                 fir_clk,
    input  logic                                 fir_rst,
    input  logic                                 wr_en,
    input  logic [IDX_W-1:0]                     wr_idx,
    input  logic [FIR_COEF_WIDTH-1:0]            wr_coef,
    input  logic [IDX_W:0]                       crr_nr,
    input  logic                                 update_req,
    input  logic                                 clr_err,
    output logic [FIR_DSP_NR*FIR_COEF_WIDTH-1:0] coefs_flat,
    output logic                                 fir_hold,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 wr_err,
    output logic [15:0]                          update_cnt
);

    import fir_pkg::*;

    localparam int W       = FIR_COEF_WIDTH;
    localparam int N       = FIR_DSP_NR;
    localparam int FLUSH_W = $clog2(N + 2);

    localparam logic [IDX_W-1:0]   LAST_TAP   = IDX_W'(N - 1);
    localparam logic [IDX_W:0]     N_CLAMP    = (IDX_W + 1)'(N);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(N + 1);

    fir_state_e         state_q, state_d;
    logic [IDX_W-1:0]   tap_idx_q, tap_idx_d;
    logic [IDX_W:0]     n_q, n_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               pending_q, pending_d;
    logic               done_q, done_d;
    logic               wr_err_q, wr_err_d;
    logic [15:0]        update_cnt_q, update_cnt_d;
    logic [W-1:0]       active_q [N];
    logic [W-1:0]       active_d [N];
    logic               update_req_q;

    logic               req_edge;
    logic               is_idle;
    logic [W-1:0]       shadow_rd;

    assign req_edge = update_req & ~update_req_q;
    assign is_idle  = (state_q == ST_IDLE);

    fir_coef_shadow #(
        .WIDTH (W),
        .DEPTH (N),
        .IDX_W (IDX_W)
    ) u_shadow (
        .clk_i     (fir_clk),
        .rst_i     (fir_rst),
        .wr_en_i   (wr_en & is_idle),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_coef),
        .rd_idx_i  (tap_idx_q),
        .rd_data_o (shadow_rd)
    );

    // Next-state, tap copy, flush timing and status bookkeeping
    always_comb begin
        state_d      = state_q;
        tap_idx_d    = tap_idx_q;
        n_d          = n_q;
        flush_cnt_d  = flush_cnt_q;
        pending_d    = pending_q;
        done_d       = 1'b0;
        update_cnt_d = update_cnt_q;
        active_d     = active_q;

        // A dropped write in the same cycle as a clear must stay visible
        wr_err_d = wr_err_q;
        if (clr_err) begin
            wr_err_d = 1'b0;
        end
        if (wr_en && !is_idle) begin
            wr_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_edge || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                    tap_idx_d = '0;
                    n_d       = (crr_nr > N_CLAMP) ? N_CLAMP : crr_nr;
                end
            end
            ST_LOAD: begin
                if (req_edge) begin
                    pending_d = 1'b1;
                end
                active_d[tap_idx_q] = ({1'b0, tap_idx_q} < n_q) ? shadow_rd : '0;
                if (tap_idx_q == LAST_TAP) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                end else begin
                    tap_idx_d = tap_idx_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (req_edge) begin
                    pending_d = 1'b1;
                end
                if (flush_cnt_q == '0) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    update_cnt_d = update_cnt_q + 16'd1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; the request edge register keeps
    // tracking through reset so a level already high at release is no edge
    always_ff @(posedge fir_clk) begin
        update_req_q <= update_req;
        if (fir_rst) begin
            state_q      <= ST_IDLE;
            tap_idx_q    <= '0;
            n_q          <= '0;
            flush_cnt_q  <= '0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
            update_cnt_q <= '0;
            for (int i = 0; i < N; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tap_idx_q    <= tap_idx_d;
            n_q          <= n_d;
            flush_cnt_q  <= flush_cnt_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            wr_err_q     <= wr_err_d;
            update_cnt_q <= update_cnt_d;
            active_q     <= active_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign coefs_flat[g*W +: W] = active_q[g];
    end

    assign busy       = !is_idle;
    assign fir_hold   = !is_idle;
    assign done       = done_q;
    assign wr_err     = wr_err_q;
    assign update_cnt = update_cnt_q;

endmodule

// File: tb/tb_fir_coef_update_ctrl.sv
// Directed bench for fir_coef_update_ctrl with a done-triggered scoreboard.
module tb_fir_coef_update_ctrl;

    localparam int N     = 32;
    localparam int W     = 18;
    localparam int IDX_W = 5;
    localparam int FW    = N * W;

    logic             fir_clk = 1'b0;
    logic             fir_rst;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [W-1:0]     wr_coef;
    logic [IDX_W:0]   crr_nr;
    logic             update_req;
    logic             clr_err;
    logic [FW-1:0]    coefs_flat;
    logic             fir_hold;
    logic             busy;
    logic             done;
    logic             wr_err;
    logic [15:0]      update_cnt;

    fir_coef_update_ctrl #(
        .FIR_COEF_WIDTH (W),
        .FIR_DSP_NR     (N),
        .IDX_W          (IDX_W)
    ) dut (
        .fir_clk    (fir_clk),
        .fir_rst    (fir_rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_coef    (wr_coef),
        .crr_nr     (crr_nr),
        .update_req (update_req),
        .clr_err    (clr_err),
        .coefs_flat (coefs_flat),
        .fir_hold   (fir_hold),
        .busy       (busy),
        .done       (done),
        .wr_err     (wr_err),
        .update_cnt (update_cnt)
    );

    always #5 fir_clk = ~fir_clk;

    typedef struct packed {
        logic [FW-1:0] taps;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    function automatic logic [FW-1:0] ramp(input int n);
        logic [FW-1:0] v;
        v = '0;
        for (int k = 0; k < n && k < N; k++) v[k*W +: W] = W'(k + 1);
        return v;
    endfunction

    function automatic logic [W-1:0] tap(input logic [FW-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    task automatic push_exp(input logic [FW-1:0] taps, input logic [15:0] cnt);
        exp_t e;
        e.taps = taps;
        e.cnt  = cnt;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge fir_clk);
        #1;
    endtask

    task automatic pulse_req();
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    task automatic wait_idle(output int len);
        len = 0;
        while (busy === 1'b1 && len < 300) begin
            len++;
            tick();
        end
    endtask

    // Monitor: every done pulse pops one expected update and compares
    initial begin : monitor
        bit   prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge fir_clk);
            if (fir_rst) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("done_width", FW'(done), '0);
                if (done === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("done_unexpected", FW'(done), '0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_taps", coefs_flat, e.taps);
                        chk("sb_cnt", FW'(update_cnt), FW'(e.cnt));
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin : stim
        int            len;
        logic [FW-1:0] v;

        fir_rst    = 1'b1;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_coef    = '0;
        crr_nr     = 6'd32;
        update_req = 1'b1;
        clr_err    = 1'b0;
        repeat (3) tick();
        fir_rst = 1'b0;
        tick();

        // Reset state, with update_req held high through reset
        chk("rst_coefs", coefs_flat, '0);
        chk("rst_busy", FW'(busy), '0);
        chk("rst_hold", FW'(fir_hold), '0);
        chk("rst_done", FW'(done), '0);
        chk("rst_wr_err", FW'(wr_err), '0);
        chk("rst_cnt", FW'(update_cnt), '0);
        repeat (5) tick();
        chk("level_high_no_update", FW'(busy), '0);
        update_req = 1'b0;
        tick();

        // Full update with per-tap timing
        for (int k = 0; k < N; k++) begin
            wr_en   = 1'b1;
            wr_idx  = IDX_W'(k);
            wr_coef = W'(k + 1);
            tick();
        end
        wr_en = 1'b0;
        push_exp(ramp(32), 16'd1);
        pulse_req();
        chk("load_busy", FW'(busy), FW'(1));
        chk("load_hold", FW'(fir_hold), FW'(1));
        len = 0;
        for (int c = 0; c < 300 && busy === 1'b1; c++) begin
            len++;
            tick();
            if (c < N) begin
                chk("tap_time", FW'(tap(coefs_flat, c)), FW'(c + 1));
                if (c < N - 1) chk("tap_early", FW'(tap(coefs_flat, c + 1)), '0);
            end
        end
        chk("busy_len", FW'(len), FW'(66));
        chk("hold_released", FW'(fir_hold), '0);
        chk("done_at_end", FW'(done), FW'(1));

        // crr_nr=5 (changed after LOAD entry), 40 (clamped), 0 (all zero)
        crr_nr = 6'd5;
        push_exp(ramp(5), 16'd2);
        pulse_req();
        crr_nr = 6'd32;
        wait_idle(len);
        chk("busy_len_n5", FW'(len), FW'(66));

        crr_nr = 6'd40;
        push_exp(ramp(32), 16'd3);
        pulse_req();
        wait_idle(len);
        chk("busy_len_n40", FW'(len), FW'(66));

        crr_nr = 6'd0;
        push_exp('0, 16'd4);
        pulse_req();
        wait_idle(len);
        chk("busy_len_n0", FW'(len), FW'(66));

        // Dropped write during FLUSH, sticky error, set-wins, clear
        crr_nr = 6'd32;
        push_exp(ramp(32), 16'd5);
        pulse_req();
        repeat (40) tick();
        wr_en   = 1'b1;
        wr_idx  = 5'd3;
        wr_coef = 18'h1FFFF;
        tick();
        wr_en = 1'b0;
        chk("wr_err_set", FW'(wr_err), FW'(1));
        wait_idle(len);
        chk("wr_err_sticky", FW'(wr_err), FW'(1));

        push_exp(ramp(32), 16'd6);
        pulse_req();
        repeat (5) tick();
        wr_en   = 1'b1;
        clr_err = 1'b1;
        tick();
        wr_en   = 1'b0;
        clr_err = 1'b0;
        chk("wr_err_set_wins", FW'(wr_err), FW'(1));
        wait_idle(len);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("wr_err_clr", FW'(wr_err), '0);

        // Three edges during LOAD collapse into one extra update
        push_exp(ramp(32), 16'd7);
        push_exp(ramp(32), 16'd8);
        pulse_req();
        repeat (3) tick();
        pulse_req();
        tick();
        pulse_req();
        tick();
        pulse_req();
        wait_idle(len);
        chk("pend_gap_busy", FW'(busy), '0);
        chk("pend_gap_done", FW'(done), FW'(1));
        tick();
        chk("pend_reload_busy", FW'(busy), FW'(1));
        wait_idle(len);
        chk("pend_len", FW'(len), FW'(66));
        repeat (10) tick();
        chk("pend_single", FW'(busy), '0);
        chk("pend_cnt", FW'(update_cnt), FW'(8));

        // Reset in the middle of LOAD at k=10
        pulse_req();
        repeat (10) tick();
        chk("midload_busy", FW'(busy), FW'(1));
        fir_rst = 1'b1;
        tick();
        fir_rst = 1'b0;
        chk("abort_coefs", coefs_flat, '0);
        chk("abort_busy", FW'(busy), '0);
        chk("abort_hold", FW'(fir_hold), '0);
        chk("abort_cnt", FW'(update_cnt), '0);
        chk("abort_done", FW'(done), '0);
        tick();

        // Shadow write in the same cycle as the request edge
        v = '0;
        v[W-1:0] = 18'h2AAAA;
        push_exp(v, 16'd1);
        wr_en      = 1'b1;
        wr_idx     = 5'd0;
        wr_coef    = 18'h2AAAA;
        update_req = 1'b1;
        tick();
        wr_en      = 1'b0;
        update_req = 1'b0;
        wait_idle(len);
        chk("busy_len_same_cycle", FW'(len), FW'(66));
        chk("same_cycle_wr_err", FW'(wr_err), '0);
        repeat (3) tick();

        chk("sb_drain", FW'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
